// File: rtl/softplus_bwd.sv
// softplus_bwd: grad_in = dy * sigmoid(x) in Q6.10, with a PLAN piecewise-linear sigmoid.
// Optional macro SOFTPLUS_BWD_ROUND_EN: both >>>10 steps round half up instead of flooring.
module softplus_bwd #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] dy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] grad_in
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEG  = 3'd1,
    MUL  = 3'd2,
    ADD  = 3'd3,
    GRAD = 3'd4,
    OUT  = 3'd5
  } state_t;

`ifdef SOFTPLUS_BWD_ROUND_EN
  localparam logic [31:0]        RND_MX   = 32'd512;
  localparam logic signed [32:0] RND_PROD = 33'sd512;
`else
  localparam logic [31:0]        RND_MX   = 32'd0;
  localparam logic signed [32:0] RND_PROD = 33'sd0;
`endif

  state_t             state_q, state_d;
  logic [15:0]        x_q, x_d;
  logic [15:0]        dy_q, dy_d;
  logic [15:0]        abs_q, abs_d;
  logic [8:0]         m_q, m_d;
  logic [10:0]        c_q, c_d;
  logic               neg_q, neg_d;
  logic               sat_hi_q, sat_hi_d;
  logic               sat_lo_q, sat_lo_d;
  logic [31:0]        mx_q, mx_d;
  logic [16:0]        s_q, s_d;
  logic [15:0]        grad_q, grad_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [16:0]        s_pos_s;
  logic signed [32:0] prod_s;

  // Next-state and datapath computation for every register.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    dy_d        = dy_q;
    abs_d       = abs_q;
    m_d         = m_q;
    c_d         = c_q;
    neg_d       = neg_q;
    sat_hi_d    = sat_hi_q;
    sat_lo_d    = sat_lo_q;
    mx_d        = mx_q;
    s_d         = s_q;
    grad_d      = grad_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    s_pos_s     = 17'(((mx_q + RND_MX) >> FRAC_W)) + {6'd0, c_q};
    prod_s      = $signed({{17{dy_q[15]}}, dy_q}) * $signed({{16{s_q[16]}}, s_q});

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d        = x;
          dy_d       = dy;
          in_ready_d = 1'b0;
          state_d    = SEG;
        end else begin
          state_d = IDLE;
        end
      end
      SEG: begin
        neg_d    = x_q[15];
        sat_hi_d = ($signed(x_q) >= 16'sd5120);
        sat_lo_d = ($signed(x_q) <= -16'sd5120);
        // -32768 wraps to itself here; it is always in the saturated-low region.
        abs_d    = x_q[15] ? 16'(-x_q) : x_q;
        if (abs_d < 16'd1024) begin
          m_d = 9'd256;
          c_d = 11'd512;
        end else if (abs_d < 16'd2432) begin
          m_d = 9'd128;
          c_d = 11'd640;
        end else begin
          m_d = 9'd32;
          c_d = 11'd864;
        end
        state_d = MUL;
      end
      MUL: begin
        mx_d    = {23'd0, m_q} * {16'd0, abs_q};
        state_d = ADD;
      end
      ADD: begin
        if (sat_hi_q) begin
          s_d = 17'd1024;
        end else if (sat_lo_q) begin
          s_d = 17'd0;
        end else if (neg_q) begin
          s_d = 17'd1024 - s_pos_s;
        end else begin
          s_d = s_pos_s;
        end
        state_d = GRAD;
      end
      GRAD: begin
        grad_d  = 16'((prod_s + RND_PROD) >>> FRAC_W);
        state_d = OUT;
      end
      OUT: begin
        // out_valid is registered, so the first OUT cycle only raises it.
        if (out_valid_q) begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = OUT;
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      x_q         <= 16'd0;
      dy_q        <= 16'd0;
      abs_q       <= 16'd0;
      m_q         <= 9'd0;
      c_q         <= 11'd0;
      neg_q       <= 1'b0;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
      mx_q        <= 32'd0;
      s_q         <= 17'd0;
      grad_q      <= 16'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      dy_q        <= dy_d;
      abs_q       <= abs_d;
      m_q         <= m_d;
      c_q         <= c_d;
      neg_q       <= neg_d;
      sat_hi_q    <= sat_hi_d;
      sat_lo_q    <= sat_lo_d;
      mx_q        <= mx_d;
      s_q         <= s_d;
      grad_q      <= grad_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign grad_in   = grad_q;

endmodule

// File: tb/tb_softplus_bwd.sv
// Directed, table-driven bench for softplus_bwd (expectations follow SOFTPLUS_BWD_ROUND_EN).
module tb_softplus_bwd;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] dy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] grad_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    xv;
    int    dyv;
    int    e_floor;
    int    e_round;
    string nm;
  } vec_t;

  vec_t vecs [14];

  softplus_bwd dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .dy       (dy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .grad_in  (grad_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pick(input vec_t v);
`ifdef SOFTPLUS_BWD_ROUND_EN
    return v.e_round;
`else
    return v.e_floor;
`endif
  endfunction

  // Accept one operand pair, check latency and result, then complete the handshake.
  task automatic run_txn(input int xv, input int dyv, input int expv, input string nm);
    int k;
    @(negedge clk);
    chk({nm, "_in_ready_idle"}, int'(in_ready), 1);
    x        = 16'(xv);
    dy       = 16'(dyv);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({nm, "_latency"}, k, 5);
    chk({nm, "_grad"}, int'($signed(grad_in)), expv);
    chk({nm, "_in_ready_busy"}, int'(in_ready), 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_out_valid_fall"}, int'(out_valid), 0);
    chk({nm, "_in_ready_rise"}, int'(in_ready), 1);
  endtask

  initial begin
    vecs[0]  = '{0,      1024,  512,   512,   "x0"};
    vecs[1]  = '{2048,   2048,  1792,  1792,  "x2048"};
    vecs[2]  = '{-2048,  2048,  256,   256,   "xm2048"};
    vecs[3]  = '{-1024,  -4096, -1024, -1024, "xm1024"};
    vecs[4]  = '{6000,   -3000, -3000, -3000, "sat_hi"};
    vecs[5]  = '{-32768, 5000,  0,     0,     "xmin"};
    vecs[6]  = '{5120,   700,   700,   700,   "x5120"};
    vecs[7]  = '{3000,   1024,  957,   958,   "x3000"};
    vecs[8]  = '{1024,   1024,  768,   768,   "x1024"};
    vecs[9]  = '{1023,   1024,  767,   768,   "x1023"};
    vecs[10] = '{2432,   1024,  940,   940,   "x2432"};
    vecs[11] = '{0,      -3,    -2,    -1,    "neg_prod"};
    vecs[12] = '{-5120,  1000,  0,     0,     "xm5120"};
    vecs[13] = '{5119,   1024,  1023,  1024,  "x5119"};

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = 16'd0;
    dy        = 16'd0;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_grad", int'(grad_in), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_txn(vecs[i].xv, vecs[i].dyv, pick(vecs[i]), vecs[i].nm);
    end

    // Backpressure: result held and new operands ignored while out_ready is low.
    @(negedge clk);
    x        = 16'd2048;
    dy       = 16'd1024;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_first_valid", int'(out_valid), 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      x        = 16'd0;
      dy       = 16'hFC00;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_grad", int'($signed(grad_in)), 896);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_out_valid", int'(out_valid), 0);
    chk("bp_release_in_ready", int'(in_ready), 1);
    chk("bp_grad_kept", int'($signed(grad_in)), 896);
    run_txn(-2048, 2048, 256, "after_bp");

    // Reset while the block is in MUL aborts the operation.
    @(negedge clk);
    x        = 16'd2048;
    dy       = 16'd2048;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_grad", int'(grad_in), 0);
    @(negedge clk);
    rst = 1'b1;
    run_txn(0, 1024, 512, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
